bs_axi_writer: RTL and testbench
================================

# bs_axi_writer

Drains the 64-bit H.264 bitstream FIFO (byte-assembled, first byte in bits [7:0]) and writes its words to a DDR ring buffer as AXI4 INCR write bursts. Sits on the AXI clock side of the encoder's bitstream FIFO and is the reader of that FIFO. It reports the ring write pointer, the total bytes written, flush completion and AXI errors to the register block.

## Interface
- BURST_LEN, 16: maximum beats per burst; power of two, 2..256.
- ADDR_W, 32: AXI address width.

- clk  in  1  AXI clock; the only clock.
- rst_n  in  1  synchronous reset, active low.
- enable  in  1  level; run while high.
- flush  in  1  one-cycle pulse; drain the FIFO completely, then pulse flush_done.
- base_addr  in  ADDR_W  ring base; must be BURST_LEN*8-byte aligned. Sampled on the enable rising edge.
- buf_size  in  32  ring size in bytes; nonzero multiple of BURST_LEN*8. Sampled with base_addr.
- fifo_q  in  64  FIFO read data; valid the cycle after fifo_rdreq.
- fifo_empty  in  1  FIFO empty.
- fifo_usedw  in  8  FIFO read-side word count; may lag and is treated as a lower bound.
- fifo_rdreq  out  1  FIFO read strobe.
- m_axi_awaddr/awlen/awsize/awburst/awvalid  out  ADDR_W/8/3/2/1  write address channel. awsize=3'd3 and awburst=2'b01, both constant.
- m_axi_awready  in  1
- m_axi_wdata/wstrb/wlast/wvalid  out  64/8/1/1  write data channel. wstrb=8'hFF, constant.
- m_axi_wready  in  1
- m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1
- wr_ptr  out  32  byte offset of the next write within the ring.
- bytes_total  out  32  bytes written since enable rose; wraps modulo 2^32.
- flush_done  out  1  one-cycle pulse.
- err  out  1  sticky; set on bresp != OKAY, cleared on enable rising.

## Operation
- States: IDLE, ADDR, DATA, RESP. Only one burst is outstanding at a time.
- On the enable rising edge: latch base_addr and buf_size, clear wr_ptr, bytes_total and err.
- Boundary headroom: room = BURST_LEN - (wr_ptr[..] / 8 mod BURST_LEN). Because of this, no burst crosses a BURST_LEN*8-byte boundary, so none crosses 4 KB or the ring end.
- IDLE priority order:
  1. If enable and fifo_usedw >= room: burst of `room` beats.
  2. Otherwise, if flush is pending and fifo_usedw > 0: burst of min(fifo_usedw, room) beats.
  3. Otherwise, if flush is pending, fifo_empty is high and fifo_usedw == 0: pulse flush_done and clear the pending flag.
- A flush pulse arriving in any state sets the pending flag. It is serviced after the current burst completes.
- Bursts are started from IDLE only while enable is high or a flush is pending. If enable falls mid-burst, the burst still completes.
- ADDR: awaddr = base + wr_ptr and awlen = n-1. Hold awvalid until awready.
- DATA:
  - A 2-entry prefetch queue feeds wdata.
  - fifo_rdreq is asserted when (queue occupancy + reads in flight) < 2, words for this burst are still unfetched, and fifo_empty is low. fifo_rdreq is never asserted outside ADDR or DATA.
  - wvalid is high whenever the queue is non-empty. wlast is asserted on beat n.
- RESP: bready is high. On bvalid:
  - If bresp != 0, set err.
  - wr_ptr += n*8; when it reaches buf_size, wr_ptr becomes 0.
  - bytes_total += n*8.
  - Return to IDLE.
- Upstream pads the stream to an 8-byte multiple before pulsing flush. This block handles no partial words.

## Timing
- Reset values: all AXI valids 0, bready 0, fifo_rdreq 0, wlast 0, wr_ptr 0, bytes_total 0, err 0, flush_done 0, flush pending flag 0, state IDLE.
- IDLE decision → awvalid high on the next cycle.
- Prefetch starts in ADDR, so the first wdata can be ready by the AW handshake. wvalid is asserted only after the AW handshake.
- With wready held high and the FIFO non-empty, the bus sustains 1 beat/cycle.
- Reset mid-burst: abandon the transaction and go to IDLE. The AXI slave must be reset together with this block.
- flush_done is asserted at least 1 cycle after the last bvalid of the drain.
- A flush with an empty FIFO and no burst in progress produces flush_done 2 cycles after the pulse.

## Structure
- Shared package `bs_axi_pkg`:
  - state enum;
  - AXI constants: AWSIZE_8B = 3'd3, BURST_INCR = 2'b01, RESP_OKAY = 2'b00.
- Sub-module `bs_prefetch_q`: 2-entry queue that accounts for the 1-cycle FIFO read latency. Ports: push_req, rd_valid, pop, count, dout.

## Test plan
- BURST_LEN=16, base 0x1000_0000, size 0x800, usedw=40, wready=1: bursts of 16, 16 at 0x1000_0000 and 0x1000_0080; 8 words remain. wr_ptr=0x100, bytes_total=256.
- Then flush: a single 8-beat burst at 0x1000_0100, then flush_done. Next burst with usedw≥8: awlen=7 at 0x1000_0140 (boundary headroom).
- Fill until wr_ptr=0x780, then 16 more words: burst at 0x1000_0780, then wr_ptr=0. The next burst goes to base.
- wready toggling 1-of-3 cycles and fifo_empty pulsing: wdata order equals FIFO order, exactly n beats, wlast on beat n, no rdreq while empty.
- bresp=2'b10 on one burst: err=1 and stays 1. Pointer still advances. An enable 0→1 cycle clears it.
- rst_n low in the middle of DATA: all outputs at reset values on the next edge. After re-enable, the first awaddr equals base_addr.

Source files
------------

// File: rtl/bs_axi_pkg.sv
// Shared types and AXI constants for the bitstream-to-DDR writer.
package bs_axi_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  localparam logic [2:0] AWSIZE_8B  = 3'd3;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/bs_prefetch_q.sv
// Two-entry prefetch queue in front of the AXI write data channel.
// A read issued on push_req lands one cycle later, while rd_valid is high.
module bs_prefetch_q (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_req,
  input  logic [63:0] din,
  input  logic        pop,
  output logic        rd_valid,
  output logic [1:0]  count,
  output logic [63:0] dout
);

  logic [63:0] mem [2];
  logic        wr_idx;
  logic        rd_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      count    <= 2'd0;
      wr_idx   <= 1'b0;
      rd_idx   <= 1'b0;
    end else begin
      rd_valid <= push_req;
      if (rd_valid) wr_idx <= ~wr_idx;
      if (pop)      rd_idx <= ~rd_idx;
      count <= count + 2'(rd_valid) - 2'(pop);
    end
  end

  // NOTE: the storage array has no reset; count alone says which entries hold data.
  always_ff @(posedge clk) begin
    if (rd_valid) mem[wr_idx] <= din;
  end

  assign dout = mem[rd_idx];

endmodule

// File: rtl/bs_axi_writer.sv
// Drains the 64-bit bitstream FIFO into a DDR ring buffer as AXI4 INCR bursts,
// one burst outstanding at a time, never crossing a BURST_LEN*8-byte boundary.
module bs_axi_writer
  import bs_axi_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       buf_size,
  input  logic [63:0]       fifo_q,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_usedw,
  output logic              fifo_rdreq,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [63:0]       m_axi_wdata,
  output logic [7:0]        m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [31:0]       wr_ptr,
  output logic [31:0]       bytes_total,
  output logic              flush_done,
  output logic              err
);

  localparam int LW = $clog2(BURST_LEN);

  state_t            state, state_next;
  logic [ADDR_W-1:0] base_r;
  logic [31:0]       size_r;
  logic              enable_q;
  logic              flush_pend;
  logic [8:0]        burst_n, fetched, beats;
  logic              start, done_set;
  logic [8:0]        n_sel;

  logic        en_rise;
  logic [8:0]  room;
  logic [8:0]  usedw9;
  logic [31:0] burst_bytes;
  logic [31:0] ptr_adv;
  logic        pop;
  logic        q_rd_valid;
  logic [1:0]  q_count;
  logic [2:0]  occ_eff;

  assign en_rise     = enable & ~enable_q;
  assign room        = 9'(BURST_LEN) - 9'(wr_ptr[LW+2:3]);
  assign usedw9      = {1'b0, fifo_usedw};
  assign burst_bytes = 32'(burst_n) << 3;
  assign ptr_adv     = wr_ptr + burst_bytes;

  bs_prefetch_q u_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_req (fifo_rdreq),
    .din      (fifo_q),
    .pop      (pop),
    .rd_valid (q_rd_valid),
    .count    (q_count),
    .dout     (m_axi_wdata)
  );

  assign m_axi_awaddr  = base_r + ADDR_W'(wr_ptr);
  assign m_axi_awlen   = 8'(burst_n - 9'd1);
  assign m_axi_awsize  = AWSIZE_8B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awvalid = (state == S_ADDR);
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_wvalid  = (state == S_DATA) && (q_count != 2'd0);
  assign m_axi_wlast   = m_axi_wvalid && (beats == burst_n - 9'd1);
  assign m_axi_bready  = (state == S_RESP);
  assign pop           = m_axi_wvalid && m_axi_wready;

  // The slot freed by this cycle's pop counts as free, which keeps 1 beat/cycle.
  assign occ_eff    = 3'(q_count) + 3'(q_rd_valid) - 3'(pop);
  assign fifo_rdreq = ((state == S_ADDR) || (state == S_DATA)) &&
                      (fetched != burst_n) && !fifo_empty && (occ_eff < 3'd2);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    done_set   = 1'b0;
    n_sel      = burst_n;
    unique case (state)
      S_IDLE: begin
        if (!en_rise) begin
          if (enable && (usedw9 >= room)) begin
            start      = 1'b1;
            n_sel      = room;
            state_next = S_ADDR;
          end else if (flush_pend && (usedw9 != 9'd0)) begin
            start      = 1'b1;
            n_sel      = (usedw9 < room) ? usedw9 : room;
            state_next = S_ADDR;
          end else if (flush_pend && fifo_empty) begin
            done_set = 1'b1;
          end
        end
      end
      S_ADDR:  if (m_axi_awready) state_next = S_DATA;
      S_DATA:  if (pop && (beats == burst_n - 9'd1)) state_next = S_RESP;
      S_RESP:  if (m_axi_bvalid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      enable_q    <= 1'b0;
      flush_pend  <= 1'b0;
      flush_done  <= 1'b0;
      burst_n     <= 9'd0;
      fetched     <= 9'd0;
      beats       <= 9'd0;
      base_r      <= '0;
      size_r      <= 32'd0;
      wr_ptr      <= 32'd0;
      bytes_total <= 32'd0;
      err         <= 1'b0;
    end else begin
      state      <= state_next;
      enable_q   <= enable;
      flush_done <= done_set;

      // A new flush pulse wins over the clear of an older one.
      if (flush)         flush_pend <= 1'b1;
      else if (done_set) flush_pend <= 1'b0;

      if (start) begin
        burst_n <= n_sel;
        fetched <= 9'd0;
        beats   <= 9'd0;
      end else begin
        if (fifo_rdreq) fetched <= fetched + 9'd1;
        if (pop)        beats   <= beats + 9'd1;
      end

      if (en_rise) begin
        base_r      <= base_addr;
        size_r      <= buf_size;
        wr_ptr      <= 32'd0;
        bytes_total <= 32'd0;
        err         <= 1'b0;
      end else if ((state == S_RESP) && m_axi_bvalid) begin
        if (m_axi_bresp != RESP_OKAY) err <= 1'b1;
        wr_ptr      <= (ptr_adv == size_r) ? 32'd0 : ptr_adv;
        bytes_total <= bytes_total + burst_bytes;
      end
    end
  end

endmodule

// File: tb/tb_bs_axi_writer.sv
// Directed bench: FIFO and AXI slave models, a burst/data scoreboard and a
// step table of push/flush actions with hand-computed pointer and byte totals.
module tb_bs_axi_writer;
  import bs_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] base_addr = 32'h1000_0000;
  logic [31:0] buf_size = 32'h800;
  logic [63:0] fifo_q = 64'd0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_usedw = 8'd0;
  logic        fifo_rdreq;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [31:0] wr_ptr;
  logic [31:0] bytes_total;
  logic        flush_done;
  logic        err;

  bs_axi_writer #(.BURST_LEN(16), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .base_addr(base_addr), .buf_size(buf_size),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw),
    .fifo_rdreq(fifo_rdreq),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .wr_ptr(wr_ptr), .bytes_total(bytes_total),
    .flush_done(flush_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  typedef struct {
    int          push;
    bit          do_flush;
    bit          stress;
    logic [1:0]  bresp;
    int          n_bursts;
    logic [31:0] first_addr;
    logic [7:0]  len;
    int          leftover;
    logic [31:0] exp_ptr;
    logic [31:0] exp_bytes;
    bit          exp_err;
  } step_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] fifo_mem[$];
  logic [63:0] exp_data[$];
  aw_t         exp_aw[$];

  int         cyc = 0;
  int         seq = 0;
  bit         stress = 1'b0;
  logic [1:0] bresp_mode = 2'b00;
  bit         aw_seen = 1'b0;
  logic [7:0] cur_len = 8'd0;
  int         beat = 0;
  int         b_owed = 0;
  int         b_count = 0;
  int         w_count = 0;
  int         fd_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_words(input int n);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = {8'hB5, 24'(seq), 32'(seq) * 32'h9E37_79B1};
      fifo_mem.push_back(w);
      exp_data.push_back(w);
      seq++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_awvalid"},     64'(m_axi_awvalid), 64'd0);
    check({tag, "_wvalid"},      64'(m_axi_wvalid),  64'd0);
    check({tag, "_wlast"},       64'(m_axi_wlast),   64'd0);
    check({tag, "_bready"},      64'(m_axi_bready),  64'd0);
    check({tag, "_rdreq"},       64'(fifo_rdreq),    64'd0);
    check({tag, "_wr_ptr"},      64'(wr_ptr),        64'd0);
    check({tag, "_bytes_total"}, 64'(bytes_total),   64'd0);
    check({tag, "_err"},         64'(err),           64'd0);
    check({tag, "_flush_done"},  64'(flush_done),    64'd0);
  endtask

  task automatic wait_b(input int target, input string name);
    int i = 0;
    while (b_count < target && i < 3000) begin
      tick();
      i++;
    end
    check(name, 64'(b_count), 64'(target));
  endtask

  // FIFO model: read data appears the cycle after fifo_rdreq.
  always @(posedge clk) begin
    if (rst_n && fifo_rdreq && !fifo_empty && fifo_mem.size() > 0)
      fifo_q <= fifo_mem.pop_front();
  end

  // Slave/FIFO drivers change at the falling edge; handshakes are judged 1 ns later.
  always @(negedge clk) begin
    cyc++;
    m_axi_awready = stress ? (cyc % 2 == 0) : 1'b1;
    m_axi_wready  = stress ? (cyc % 3 == 0) : 1'b1;
    fifo_empty    = (fifo_mem.size() == 0) || (stress && (cyc % 5 == 1));
    fifo_usedw    = (fifo_mem.size() > 255) ? 8'd255 : 8'(fifo_mem.size());
    m_axi_bvalid  = (b_owed > 0);
    m_axi_bresp   = m_axi_bvalid ? bresp_mode : 2'b00;
    #1;
    if (rst_n) begin
      if (fifo_rdreq) check("rdreq_while_empty", 64'(fifo_empty), 64'd0);
      if (m_axi_wvalid) check("wvalid_after_aw", 64'(aw_seen), 64'd1);
      if (m_axi_awvalid && m_axi_awready) begin
        aw_t e;
        check("awsize", 64'(m_axi_awsize), 64'(AWSIZE_8B));
        check("awburst", 64'(m_axi_awburst), 64'(BURST_INCR));
        check("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
        if (exp_aw.size() != 0) begin
          e = exp_aw.pop_front();
          check("awaddr", 64'(m_axi_awaddr), 64'(e.addr));
          check("awlen", 64'(m_axi_awlen), 64'(e.len));
        end
        aw_seen = 1'b1;
        cur_len = m_axi_awlen;
        beat    = 0;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        check("wstrb", 64'(m_axi_wstrb), 64'hFF);
        check("wlast", 64'(m_axi_wlast), 64'(beat == int'(cur_len)));
        check("wdata_expected", 64'(exp_data.size() != 0), 64'd1);
        if (exp_data.size() != 0) check("wdata", m_axi_wdata, exp_data.pop_front());
        beat++;
        w_count++;
        if (m_axi_wlast) begin
          aw_seen = 1'b0;
          b_owed++;
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_owed--;
        b_count++;
      end
      if (flush_done) fd_count++;
    end
  end

  initial begin
    step_t steps[9];
    int    tgt;
    int    fd_tgt;
    int    w0;
    int    i;

    steps[0] = '{40,  1'b0, 1'b0, 2'b00, 2,  32'h1000_0000, 8'd15, 8, 32'h100, 32'h100, 1'b0};
    steps[1] = '{0,   1'b1, 1'b0, 2'b00, 1,  32'h1000_0100, 8'd7,  0, 32'h140, 32'h140, 1'b0};
    steps[2] = '{8,   1'b0, 1'b0, 2'b00, 1,  32'h1000_0140, 8'd7,  0, 32'h180, 32'h180, 1'b0};
    steps[3] = '{192, 1'b0, 1'b0, 2'b00, 12, 32'h1000_0180, 8'd15, 0, 32'h780, 32'h780, 1'b0};
    steps[4] = '{16,  1'b0, 1'b0, 2'b00, 1,  32'h1000_0780, 8'd15, 0, 32'h000, 32'h800, 1'b0};
    steps[5] = '{16,  1'b0, 1'b0, 2'b00, 1,  32'h1000_0000, 8'd15, 0, 32'h080, 32'h880, 1'b0};
    steps[6] = '{32,  1'b0, 1'b1, 2'b00, 2,  32'h1000_0080, 8'd15, 0, 32'h180, 32'h980, 1'b0};
    steps[7] = '{16,  1'b0, 1'b0, 2'b10, 1,  32'h1000_0180, 8'd15, 0, 32'h200, 32'hA00, 1'b1};
    steps[8] = '{16,  1'b0, 1'b0, 2'b00, 1,  32'h1000_0200, 8'd15, 0, 32'h280, 32'hA80, 1'b1};

    repeat (3) tick();
    check_reset("reset");
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    repeat (2) tick();

    // Flush with nothing buffered: flush_done exactly two cycles after the pulse.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_empty_c1", 64'(flush_done), 64'd0);
    tick();
    check("flush_empty_c2", 64'(flush_done), 64'd1);
    tick();
    check("flush_empty_c3", 64'(flush_done), 64'd0);
    check("flush_empty_no_burst", 64'(b_count), 64'd0);

    for (int s = 0; s < 9; s++) begin
      stress     = steps[s].stress;
      bresp_mode = steps[s].bresp;
      for (int k = 0; k < steps[s].n_bursts; k++)
        exp_aw.push_back('{steps[s].first_addr + 32'(k * (int'(steps[s].len) + 1) * 8), steps[s].len});
      tgt    = b_count + steps[s].n_bursts;
      fd_tgt = fd_count + (steps[s].do_flush ? 1 : 0);
      push_words(steps[s].push);
      if (steps[s].do_flush) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      wait_b(tgt, $sformatf("step%0d_bursts", s));
      i = 0;
      while (fd_count < fd_tgt && i < 100) begin
        tick();
        i++;
      end
      check($sformatf("step%0d_flush_done", s), 64'(fd_count), 64'(fd_tgt));
      repeat (4) tick();
      check($sformatf("step%0d_wr_ptr", s), 64'(wr_ptr), 64'(steps[s].exp_ptr));
      check($sformatf("step%0d_bytes", s), 64'(bytes_total), 64'(steps[s].exp_bytes));
      check($sformatf("step%0d_err", s), 64'(err), 64'(steps[s].exp_err));
      check($sformatf("step%0d_aw_left", s), 64'(exp_aw.size()), 64'd0);
      check($sformatf("step%0d_fifo_left", s), 64'(fifo_mem.size()), 64'(steps[s].leftover));
      check($sformatf("step%0d_data_left", s), 64'(exp_data.size()), 64'(steps[s].leftover));
    end
    stress     = 1'b0;
    bresp_mode = 2'b00;

    // Enable 0->1 clears the sticky error and both counters.
    enable = 1'b0;
    tick();
    enable = 1'b1;
    repeat (2) tick();
    check("reenable_err", 64'(err), 64'd0);
    check("reenable_wr_ptr", 64'(wr_ptr), 64'd0);
    check("reenable_bytes", 64'(bytes_total), 64'd0);

    // Reset in the middle of the data phase.
    exp_aw.push_back('{32'h1000_0000, 8'd15});
    push_words(16);
    w0 = w_count;
    i  = 0;
    while (w_count < w0 + 3 && i < 200) begin
      tick();
      i++;
    end
    check("midburst_reached_data", 64'(w_count >= w0 + 3), 64'd1);
    rst_n     = 1'b0;
    base_addr = 32'h2000_0000;
    tick();
    check_reset("midburst_reset");
    fifo_mem.delete();
    exp_data.delete();
    exp_aw.delete();
    aw_seen = 1'b0;
    b_owed  = 0;
    rst_n   = 1'b1;
    repeat (2) tick();
    exp_aw.push_back('{32'h2000_0000, 8'd15});
    push_words(16);
    wait_b(b_count + 1, "after_reset_burst");
    repeat (4) tick();
    check("after_reset_aw_left", 64'(exp_aw.size()), 64'd0);
    check("after_reset_wr_ptr", 64'(wr_ptr), 64'h80);
    check("after_reset_bytes", 64'(bytes_total), 64'h80);
    check("after_reset_err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
